// File: rtl/seq_alu_pkg.sv
// Shared constants for the sequential ALU: mode map and FSM state encoding.
package seq_alu_pkg;

  localparam logic [3:0] MODE_ADD  = 4'd0;
  localparam logic [3:0] MODE_SUB  = 4'd1;
  localparam logic [3:0] MODE_AND  = 4'd2;
  localparam logic [3:0] MODE_OR   = 4'd3;
  localparam logic [3:0] MODE_XOR  = 4'd4;
  localparam logic [3:0] MODE_NOT  = 4'd5;
  localparam logic [3:0] MODE_INC  = 4'd6;
  localparam logic [3:0] MODE_DEC  = 4'd7;
  localparam logic [3:0] MODE_SLL0 = 4'd8;
  localparam logic [3:0] MODE_SLL1 = 4'd9;
  localparam logic [3:0] MODE_SRL0 = 4'd10;
  localparam logic [3:0] MODE_SRL1 = 4'd11;
  localparam logic [3:0] MODE_SLA  = 4'd12;
  localparam logic [3:0] MODE_SRA  = 4'd13;
  localparam logic [3:0] MODE_ROL  = 4'd14;
  localparam logic [3:0] MODE_ROR  = 4'd15;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic is_shift(input logic [3:0] mode);
    return mode[3];
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/result bundle between the operand register file, seq_alu and writeback.
interface seq_alu_if #(
  parameter int WIDTH = 8
);
  localparam int SHW = $clog2(WIDTH);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [3:0]       m;
  logic [SHW-1:0]   shamt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] r;
  logic             overflow;
  logic             carry;
  logic             zero;

  modport master (output start, a, b, cin, m, shamt,
                  input  busy, done, r, overflow, carry, zero);
  modport slave  (input  start, a, b, cin, m, shamt,
                  output busy, done, r, overflow, carry, zero);
endinterface

// File: rtl/seq_alu_step.sv
// Combinational core: one full arithmetic/logic result, or one single-bit
// shift/rotate step applied to val, together with its carry and overflow.
module seq_alu_step
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [3:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [WIDTH-1:0] val,
  output logic [WIDTH-1:0] res,
  output logic             carry,
  output logic             ovf
);
  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0] ext;

  always_comb begin
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    ext   = '0;
    case (mode)
      MODE_ADD: begin
        ext   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        res   = ext[MSB:0];
        carry = ext[WIDTH];
        ovf   = (a[MSB] == b[MSB]) && (res[MSB] != a[MSB]);
      end
      MODE_SUB: begin
        // Top bit of the widened difference is the unsigned borrow.
        ext   = {1'b0, a} - {1'b0, b};
        res   = ext[MSB:0];
        carry = ext[WIDTH];
        ovf   = (a[MSB] != b[MSB]) && (res[MSB] != a[MSB]);
      end
      MODE_AND: res = a & b;
      MODE_OR:  res = a | b;
      MODE_XOR: res = a ^ b;
      MODE_NOT: res = ~a;
      MODE_INC: begin
        res   = a + WIDTH'(1);
        carry = &a;
        ovf   = ~a[MSB] & (&a[MSB-1:0]);
      end
      MODE_DEC: begin
        res   = a - WIDTH'(1);
        carry = ~|a;
        ovf   = a[MSB] & ~|a[MSB-1:0];
      end
      MODE_SLL0, MODE_SLA: begin
        res   = {val[MSB-1:0], 1'b0};
        carry = val[MSB];
        ovf   = (mode == MODE_SLA) && (val[MSB] != val[MSB-1]);
      end
      MODE_SLL1: begin
        res   = {val[MSB-1:0], 1'b1};
        carry = val[MSB];
      end
      MODE_SRL0: begin
        res   = {1'b0, val[MSB:1]};
        carry = val[0];
      end
      MODE_SRL1: begin
        res   = {1'b1, val[MSB:1]};
        carry = val[0];
      end
      MODE_SRA: begin
        res   = {val[MSB], val[MSB:1]};
        carry = val[0];
      end
      MODE_ROL: begin
        res   = {val[MSB-1:0], val[MSB]};
        carry = val[MSB];
      end
      MODE_ROR: begin
        res   = {val[0], val[MSB:1]};
        carry = val[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with start/busy/done handshake and registered result/flags.
// Define SEQ_ALU_BARREL_EN to resolve shifts in a single EXEC cycle.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input logic      clk,
  input logic      rst,
  seq_alu_if.slave bus
);
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             cin_q, cin_d;
  logic [3:0]       m_q, m_d;
  logic [SHW-1:0]   shamt_q, shamt_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             carry_q, carry_d, overflow_q, overflow_d, zero_q, zero_d;

  // Result of the current EXEC cycle and whether it is the final one.
  logic             ex_last;
  logic [WIDTH-1:0] ex_res;
  logic             ex_carry, ex_ovf;

`ifdef SEQ_ALU_BARREL_EN
  localparam int NSTG = 1 << SHW;

  logic [WIDTH-1:0] sel_res   [NSTG];
  logic             sel_carry [NSTG];
  logic             sel_ovf   [NSTG];

  assign sel_res[0]   = a_q;
  assign sel_carry[0] = 1'b0;
  assign sel_ovf[0]   = 1'b0;

  // Stage gi performs step gi+1; SLA overflow accumulates down the chain.
  for (genvar gi = 0; gi < NSTG - 1; gi++) begin : g_stage
    logic [WIDTH-1:0] vin, res;
    logic             c, v, acc;
    if (gi == 0) begin : g_first
      assign vin = a_q;
      assign acc = v;
    end else begin : g_next
      assign vin = g_stage[gi-1].res;
      assign acc = g_stage[gi-1].acc | v;
    end
    seq_alu_step #(.WIDTH(WIDTH)) u_step (
      .mode(m_q), .a(a_q), .b(b_q), .cin(cin_q), .val(vin),
      .res(res), .carry(c), .ovf(v)
    );
    assign sel_res[gi+1]   = res;
    assign sel_carry[gi+1] = c;
    assign sel_ovf[gi+1]   = acc;
  end

  always_comb begin
    ex_last  = 1'b1;
    ex_res   = sel_res[1];
    ex_carry = sel_carry[1];
    ex_ovf   = sel_ovf[1];
    if (is_shift(m_q)) begin
      ex_res   = sel_res[shamt_q];
      ex_carry = sel_carry[shamt_q];
      ex_ovf   = sel_ovf[shamt_q];
    end
  end
`else
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic             ovf_acc_q, ovf_acc_d;
  logic [WIDTH-1:0] step_res;
  logic             step_carry, step_ovf;
  logic             shamt_zero;

  seq_alu_step #(.WIDTH(WIDTH)) u_step (
    .mode(m_q), .a(a_q), .b(b_q), .cin(cin_q), .val(work_q),
    .res(step_res), .carry(step_carry), .ovf(step_ovf)
  );

  assign shamt_zero = (shamt_q == '0);

  always_comb begin
    cnt_d     = cnt_q;
    work_d    = work_q;
    ovf_acc_d = ovf_acc_q;
    ex_last   = !is_shift(m_q) || shamt_zero || (cnt_q == SHW'(1));
    ex_res    = step_res;
    ex_carry  = step_carry;
    ex_ovf    = step_ovf;
    if (is_shift(m_q)) begin
      ex_ovf = ovf_acc_q | step_ovf;
      // A zero shift still spends one EXEC cycle but passes a through untouched.
      if (shamt_zero) begin
        ex_res   = work_q;
        ex_carry = 1'b0;
        ex_ovf   = 1'b0;
      end
    end
    if (state_q == ST_IDLE && bus.start) begin
      cnt_d     = shamt_zero_in(bus.shamt) ? SHW'(1) : bus.shamt;
      work_d    = bus.a;
      ovf_acc_d = 1'b0;
    end else if (state_q == ST_EXEC && is_shift(m_q)) begin
      cnt_d     = cnt_q - SHW'(1);
      work_d    = step_res;
      ovf_acc_d = ex_ovf;
    end
  end

  function automatic logic shamt_zero_in(input logic [SHW-1:0] s);
    return s == '0;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      work_q    <= '0;
      ovf_acc_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      ovf_acc_q <= ovf_acc_d;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    cin_d      = cin_q;
    m_d        = m_q;
    shamt_d    = shamt_q;
    r_d        = r_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          cin_d   = bus.cin;
          m_d     = bus.m;
          shamt_d = bus.shamt;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (ex_last) begin
          r_d        = ex_res;
          carry_d    = ex_carry;
          overflow_d = ex_ovf;
          zero_d     = (ex_res == '0);
          state_d    = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      cin_q      <= 1'b0;
      m_q        <= '0;
      shamt_q    <= '0;
      r_q        <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cin_q      <= cin_d;
      m_q        <= m_d;
      shamt_q    <= shamt_d;
      r_q        <= r_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
    end
  end

  assign bus.busy     = (state_q == ST_EXEC);
  assign bus.done     = (state_q == ST_DONE);
  assign bus.r        = r_q;
  assign bus.carry    = carry_q;
  assign bus.overflow = overflow_q;
  assign bus.zero     = zero_q;

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, multi-cycle successor to the 4-bit combinational ALU.
- Covers the same 16-mode map: 8 arithmetic/logic ops (m=0..7) and 8 shift/rotate ops (m=8..15).
- Generalised to WIDTH bits with a variable shift amount.
- Uses a start/busy/done handshake and registered results plus flags.
- Sits between the operand register file and the result writeback in the lab datapath.

Parameters:
WIDTH, 8, operand/result width in bits (>=4)
SHW, $clog2(WIDTH), width of shift-amount port (derived; do not override)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
start  in  1  request; sampled only in IDLE
a  in  WIDTH  operand A
b  in  WIDTH  operand B
cin  in  1  carry-in (ADD only)
m  in  4  mode select
shamt  in  SHW  shift/rotate amount (m>=8)
busy  out  1  high while in EXEC
done  out  1  one-cycle pulse, result valid
r  out  WIDTH  result, held until next accepted start
overflow  out  1  signed overflow flag
carry  out  1  carry/borrow/last-bit-out flag
zero  out  1  r==0

Behaviour:
- Reset (async, any state): state=IDLE; r=0, overflow=0, carry=0, zero=0, busy=0, done=0. An in-flight op is discarded.
- States: IDLE -> EXEC -> DONE -> IDLE.
- IDLE:
  - On start=1, capture a, b, cin, m, shamt into internal registers and go to EXEC. done=0.
- EXEC, busy=1:
  - m<8: result is computed in one cycle, then go to DONE.
  - m>=8: cnt is loaded with max(shamt,1) at capture. Each EXEC cycle applies a one-bit step and decrements cnt. When cnt reaches 1, go to DONE.
  - shamt=0 takes one cycle and gives r=a, carry=0, overflow=0.
- DONE:
  - done=1 for exactly one cycle; r and flags are registered on entry to DONE.
  - Return to IDLE. A start in DONE is ignored.
  - Latency from start edge to done: arithmetic/logic = 2 cycles; shift = 1+max(shamt,1) cycles.
- start while busy or done: ignored, no queuing. Captured operands are immune to input changes after capture.
- Mode map; all arithmetic is modulo 2^WIDTH:
  - 0 ADD: a+b+cin. carry = unsigned carry-out. overflow = signed overflow.
  - 1 SUB: a-b. carry = borrow (a<b unsigned). overflow = signed overflow.
  - 2 AND, 3 OR, 4 XOR, 5 NOT a: carry=0, overflow=0.
  - 6 INC a+1: overflow when a=0111..1; carry when a=all-ones.
  - 7 DEC a-1: overflow when a=1000..0; carry (borrow) when a=0.
  - 8 SLL fill 0, 9 SLL fill 1.
  - 10 SRL fill 0, 11 SRL fill 1.
  - 12 SLA: fill 0. overflow is sticky if the MSB changes on any step.
  - 13 SRA: MSB replicated.
  - 14 ROL, 15 ROR.
  - For m>=8 other than SLA, overflow=0.
  - For all m>=8, carry = last bit shifted or rotated out.
- zero is recomputed from the final r on entry to DONE.

Optional Feature:
SEQ_ALU_BARREL_EN
- Defined: shifts/rotates use a combinational barrel shifter. Every mode completes with a single EXEC cycle, so latency is 2 for all ops. SLA overflow = any of the top shamt+1 bits of a differ from the original MSB. carry = bit shifted out last.
- Undefined: iterative one-bit-per-cycle shifter as above.
- Results and flags are identical in both builds; only latency differs.

Decomposition:
- seq_alu_pkg holds:
  - Mode constants MODE_ADD..MODE_ROR (4-bit).
  - State encoding ST_IDLE/ST_EXEC/ST_DONE.
- Natural sub-module: seq_alu_step, a combinational block that computes one arithmetic result or one single-bit shift step plus flags.
- seq_alu holds the FSM, counter and registers.

Test Plan:
All cases use WIDTH=8.
1. ADD a=0x7F b=0x01 cin=0, start -> done 2 cycles later, r=0x80 overflow=1 carry=0 zero=0. Then ADD 0xFF+0x01 -> r=0x00 carry=1 zero=1.
2. SUB a=0x05 b=0x07 -> r=0xFE carry=1 overflow=0. SUB 0x80-0x01 -> r=0x7F overflow=1.
3. SRA a=0x90 shamt=3 -> busy for 3 cycles, r=0xF2 carry=0. ROL a=0x81 shamt=1 -> r=0x03 carry=1.
4. SLA a=0x30 shamt=2 -> r=0xC0 overflow=1. SLL fill-1 a=0x01 shamt=0 -> r=0x01, EXEC one cycle.
5. Start ROR shamt=7, then pulse start again mid-EXEC with new a -> second start ignored, result from the first operands only. Then assert rst mid-EXEC -> all outputs 0 immediately, state IDLE, no done pulse.
6. With SEQ_ALU_BARREL_EN defined, rerun cases 3 and 4 -> identical r/flags, done always 2 cycles after start.
